// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/arith ops, bit-serial shifts, shift-add multiply
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] W_LIM    = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    W_CNT    = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     sh_reg;
  logic [2*WIDTH-1:0]   prod;
  logic [CW-1:0]        cnt;
  logic                 mul_mode;
  logic                 shl_mode;
  logic                 accept;

  logic [WIDTH:0]       add_ext;
  logic [WIDTH:0]       sub_ext;
  logic [WIDTH-1:0]     sc_result;
  logic                 sc_carry;
  logic                 sc_ovf;
  logic                 sc_illegal;
  logic [CW-1:0]        shamt;
  logic                 multi;

  logic [WIDTH-1:0]     sh_next;
  logic                 sh_bit;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH-1:0]     fin_result;
  logic                 fin_carry;

  // Ready is forced low under reset; in DONE a new request may only enter while the current result is consumed
  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath and classification of the incoming request
  always_comb begin
    add_ext    = {1'b0, A} + {1'b0, B};
    sub_ext    = {1'b0, A} - {1'b0, B};
    shamt      = (B >= W_LIM) ? W_CNT : B[CW-1:0];
    multi      = 1'b0;
    sc_result  = '0;
    sc_carry   = 1'b0;
    sc_ovf     = 1'b0;
    sc_illegal = 1'b0;
    case (opcode)
      OP_AND: sc_result = A & B;
      OP_OR:  sc_result = A | B;
      OP_XOR: sc_result = A ^ B;
      OP_NOT: sc_result = ~A;
      OP_ADD: begin
        sc_result = add_ext[WIDTH-1:0];
        sc_carry  = add_ext[WIDTH];
        sc_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (add_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        sc_result = sub_ext[WIDTH-1:0];
        sc_carry  = sub_ext[WIDTH];
        sc_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (sub_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_INC: begin
        sc_result = A + ONE_V;
        sc_carry  = (A == ONES);
        sc_ovf    = (A == MAX_POS);
      end
      OP_DEC: begin
        sc_result = A - ONE_V;
        sc_carry  = (A == '0);
        sc_ovf    = (A == MSB_ONLY);
      end
      // A zero-length shift completes immediately and passes A through
      OP_SHL, OP_SHR: begin
        sc_result = A;
        multi     = (shamt != '0);
      end
      OP_MUL: multi = 1'b1;
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration of the serial engines, plus the values committed on the final iteration
  always_comb begin
    if (shl_mode) begin
      sh_next = {sh_reg[WIDTH-2:0], 1'b0};
      sh_bit  = sh_reg[WIDTH-1];
    end else begin
      sh_next = {1'b0, sh_reg[WIDTH-1:1]};
      sh_bit  = sh_reg[0];
    end
    // Upper half accumulates A when the current multiplier bit is set, then the pair shifts right
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
    prod_next = {mul_sum, prod[WIDTH-1:1]};
    if (mul_mode) begin
      fin_result = prod_next[WIDTH-1:0];
      fin_carry  = |prod_next[2*WIDTH-1:WIDTH];
    end else begin
      fin_result = sh_next;
      fin_carry  = sh_bit;
    end
  end

  // Control FSM with registered result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      carry_out  <= 1'b0;
      zero_flag  <= 1'b0;
      neg_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
      illegal_op <= 1'b0;
      a_reg      <= '0;
      sh_reg     <= '0;
      prod       <= '0;
      cnt        <= '0;
      mul_mode   <= 1'b0;
      shl_mode   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (multi) begin
              state     <= BUSY;
              out_valid <= 1'b0;
              a_reg     <= A;
              sh_reg    <= A;
              prod      <= {{WIDTH{1'b0}}, B};
              mul_mode  <= (opcode == OP_MUL);
              shl_mode  <= (opcode == OP_SHL);
              cnt       <= (opcode == OP_MUL) ? W_CNT : shamt;
            end else begin
              state      <= DONE;
              out_valid  <= 1'b1;
              result     <= sc_result;
              carry_out  <= sc_carry;
              zero_flag  <= (sc_result == '0);
              neg_flag   <= sc_result[WIDTH-1];
              ovf_flag   <= sc_ovf;
              illegal_op <= sc_illegal;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (mul_mode) begin
            prod <= prod_next;
          end else begin
            sh_reg <= sh_next;
          end
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            result     <= fin_result;
            carry_out  <= fin_carry;
            zero_flag  <= (fin_result == '0);
            neg_flag   <= fin_result[WIDTH-1];
            ovf_flag   <= 1'b0;
            illegal_op <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept a request this cycle.
REQ-006 Port: A  input  WIDTH  operand A, sampled on acceptance.
REQ-007 Port: B  input  WIDTH  operand B, sampled on acceptance.
REQ-008 Port: opcode  input  4  operation select, sampled on acceptance.
REQ-009 Port: out_valid  output  1  result and flags valid.
REQ-010 Port: out_ready  input  1  consumer takes result this cycle.
REQ-011 Port: result  output  WIDTH  registered result.
REQ-012 Port: carry_out, zero_flag, neg_flag, ovf_flag, illegal_op  output  1 each  registered status flags.

Function
REQ-013 Acceptance SHALL occur on a rising edge with in_valid && in_ready; A, B, opcode captured then, ignored otherwise.
REQ-014 in_ready SHALL be 1 in IDLE, 1 in DONE only when out_ready=1, 0 in BUSY, 0 while rst=1.
REQ-015 FSM states: IDLE, BUSY, DONE; IDLE->DONE on single-cycle op, IDLE->BUSY on SHL/SHR with shift>0 or MUL, BUSY->DONE on final iteration, DONE->IDLE on out_ready without new acceptance, DONE->DONE/BUSY on out_ready with new acceptance.
REQ-016 Single-cycle opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB (A-B), 4 XOR, 5 NOT A, 6 INC A, 7 DEC A, 11 CMP (result = A-B, flags as SUB); out_valid SHALL rise the edge after acceptance (latency 1).
REQ-017 Opcodes 8 SHL, 9 SHR (logical): shift amount s = min(B unsigned, WIDTH); one bit per cycle; out_valid SHALL rise s+1 edges after acceptance (s=0 -> latency 1, result = A).
REQ-018 Opcode 10 MUL: unsigned shift-add, one multiplier bit per cycle; result = low WIDTH bits of A*B; out_valid SHALL rise WIDTH+1 edges after acceptance.
REQ-019 Opcodes 12..15: result 0, all arithmetic flags 0, illegal_op=1, latency 1; illegal_op=0 for all legal opcodes.
REQ-020 carry_out: ADD carry out of MSB; SUB/CMP/DEC borrow (1 when A<B unsigned, DEC when A=0); INC 1 when A all-ones; SHL/SHR last bit shifted out (0 when s=0); MUL 1 when high WIDTH bits of product nonzero; logic ops 0.
REQ-021 ovf_flag: signed two's-complement overflow for ADD, SUB, CMP, INC, DEC; 0 for all other ops.
REQ-022 zero_flag = (result==0); neg_flag = result[WIDTH-1]; both for every op including illegal.
REQ-023 All arithmetic wraps modulo 2^WIDTH.
REQ-024 While out_valid=1 and out_ready=0, result and all flags SHALL hold stable; no new acceptance.
REQ-025 out_valid SHALL drop the edge after out_ready=1 unless a single-cycle op is accepted that same edge, in which case out_valid stays 1 with the new result (throughput 1/cycle).
REQ-026 in_valid during BUSY SHALL be ignored and not queued.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, out_valid=0, result=0, all flags 0, discarding any in-flight op.
REQ-028 Reset mid-BUSY SHALL abort with no out_valid pulse; first acceptance possible the edge after rst deasserts.

Verification
REQ-029 WIDTH=8, ADD A=0xFF B=0x01, out_ready=1 -> next edge result=0x00, carry=1, zero=1, neg=0, ovf=0, out_valid one cycle.
REQ-030 SUB A=0x80 B=0x01 -> result=0x7F, carry=0, ovf=1, neg=0; CMP A=0x05 B=0x07 -> result=0xFE, carry=1, neg=1.
REQ-031 MUL A=0x0F B=0x11 -> result=0xFF, carry=0, out_valid 9 edges after acceptance; MUL 0x10*0x10 -> result=0x00, carry=1, zero=1.
REQ-032 SHL A=0x81 B=1 -> result=0x02, carry=1, latency 2; SHR A=0x81 B=9 -> s=8, result=0x00, carry=1, zero=1, latency 9.
REQ-033 Back-to-back ADDs with out_valid/in_valid held high, out_ready toggling 1,0,1 -> one result per out_ready=1 cycle, outputs frozen and in_ready=0 during out_ready=0.
REQ-034 MUL accepted, rst=1 on 4th cycle -> out_valid never asserts, result=0, in_ready=1 edge after rst drops; opcode 13 -> illegal_op=1, result=0, zero=1.
